// File: rtl/serial_pkg.sv
// Types and helpers shared by the serial transmitter and receiver blocks.
package serial_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    // Counter width able to hold WIDTH, the largest frame index (data + parity).
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready word intake and bit strobe.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_data,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_BITS = WIDTH + 1;
`else
    localparam int unsigned FRAME_BITS = WIDTH;
`endif
    localparam int unsigned CW = cnt_width(WIDTH);

    state_t                state, state_d;
    logic [FRAME_BITS-1:0] frame, frame_d, load;
    logic [CW-1:0]         cnt, cnt_d;
    logic                  data_d, valid_d, last_d;
    logic                  accept;

    assign par_ready = (state == IDLE) | ((state == SHIFT) & ser_last);
    assign accept    = par_valid & par_ready;
    assign busy      = (state == SHIFT);

    // Frame image arranged so the first bit to send sits at the shift-out end.
    always_comb begin
`ifdef PISO_PARITY_EN
        if (MSB_FIRST != 0) load = {par_data, ^par_data};
        else                load = {^par_data, par_data};
`else
        load = par_data;
`endif
    end

    always_comb begin
        state_d = state;
        frame_d = frame;
        cnt_d   = cnt;
        data_d  = ser_data;
        valid_d = ser_valid;
        last_d  = ser_last;
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = CW'(FRAME_BITS - 1);
            valid_d = 1'b1;
            last_d  = 1'b0;
            if (MSB_FIRST != 0) begin
                data_d  = load[FRAME_BITS-1];
                frame_d = load << 1;
            end else begin
                data_d  = load[0];
                frame_d = load >> 1;
            end
        end else if (state == SHIFT) begin
            if (ser_last) begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                data_d  = 1'b0;
            end else begin
                cnt_d  = cnt - CW'(1);
                last_d = (cnt == CW'(1));
                if (MSB_FIRST != 0) begin
                    data_d  = frame[FRAME_BITS-1];
                    frame_d = frame << 1;
                end else begin
                    data_d  = frame[0];
                    frame_d = frame >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            frame     <= '0;
            cnt       <= '0;
            ser_data  <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= state_d;
            frame     <= frame_d;
            cnt       <= cnt_d;
            ser_data  <= data_d;
            ser_valid <= valid_d;
            ser_last  <= last_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances,
// frame contents, back-to-back, async reset abort, mid-frame input changes.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] m_data, l_data;
    logic       m_valid, l_valid;
    logic       m_ready, m_sdata, m_svalid, m_slast, m_busy;
    logic       l_ready, l_sdata, l_svalid, l_slast, l_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .par_data(m_data), .par_valid(m_valid),
        .par_ready(m_ready), .ser_data(m_sdata), .ser_valid(m_svalid),
        .ser_last(m_slast), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .par_data(l_data), .par_valid(l_valid),
        .par_ready(l_ready), .ser_data(l_sdata), .ser_valid(l_svalid),
        .ser_last(l_slast), .busy(l_busy)
    );

    task automatic test_reset;
        rst = 1'b1; m_data = '0; m_valid = 1'b0; l_data = '0; l_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({m_sdata, m_svalid, m_slast, m_busy} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_outputs got=%b exp=0000", {m_sdata, m_svalid, m_slast, m_busy});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m_ready !== 1'b1 || l_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready got=%b%b exp=11", m_ready, l_ready);
        end
    endtask

    task automatic test_msb_first;
        logic [FB-1:0] exp;
`ifdef PISO_PARITY_EN
        exp = 9'b1010_0101_0;
`else
        exp = 8'b1010_0101;
`endif
        m_data = 8'hA5; m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        for (int i = 0; i < FB; i++) begin
            n_cmp++;
            if (m_svalid !== 1'b1 || m_sdata !== exp[FB-1-i] || m_slast !== (i == FB-1)) begin
                n_bad++; $display("FAIL msb_a5 bit%0d got v=%b d=%b l=%b exp v=1 d=%b l=%b",
                                  i, m_svalid, m_sdata, m_slast, exp[FB-1-i], (i == FB-1));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (m_svalid !== 1'b0 || m_ready !== 1'b1 || m_busy !== 1'b0) begin
            n_bad++; $display("FAIL msb_a5_idle got v=%b r=%b b=%b exp v=0 r=1 b=0", m_svalid, m_ready, m_busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [2*FB-1:0] exp;
`ifdef PISO_PARITY_EN
        exp = {9'b1010_0101_0, 9'b0011_1100_0};
`else
        exp = {8'b1010_0101, 8'b0011_1100};
`endif
        m_data = 8'hA5; m_valid = 1'b1;
        @(negedge clk);
        m_data = 8'h3C;
        for (int i = 0; i < 2*FB; i++) begin
            n_cmp++;
            if (m_svalid !== 1'b1 || m_sdata !== exp[2*FB-1-i] || m_slast !== ((i % FB) == FB-1)
                || m_ready !== ((i % FB) == FB-1)) begin
                n_bad++; $display("FAIL b2b bit%0d got v=%b d=%b l=%b r=%b exp v=1 d=%b l=%b r=%b",
                                  i, m_svalid, m_sdata, m_slast, m_ready, exp[2*FB-1-i],
                                  ((i % FB) == FB-1), ((i % FB) == FB-1));
            end
            if (i == FB) m_valid = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (m_svalid !== 1'b0 || m_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_idle got v=%b r=%b exp v=0 r=1", m_svalid, m_ready);
        end
    endtask

    task automatic test_lsb_first;
        logic [FB-1:0] exp;
`ifdef PISO_PARITY_EN
        exp = 9'b1000_0000_1;
`else
        exp = 8'b1000_0000;
`endif
        l_data = 8'h01; l_valid = 1'b1;
        @(negedge clk);
        l_valid = 1'b0;
        for (int i = 0; i < FB; i++) begin
            n_cmp++;
            if (l_svalid !== 1'b1 || l_sdata !== exp[FB-1-i] || l_slast !== (i == FB-1)) begin
                n_bad++; $display("FAIL lsb_01 bit%0d got v=%b d=%b l=%b exp v=1 d=%b l=%b",
                                  i, l_svalid, l_sdata, l_slast, exp[FB-1-i], (i == FB-1));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (l_svalid !== 1'b0 || l_busy !== 1'b0) begin
            n_bad++; $display("FAIL lsb_idle got v=%b b=%b exp v=0 b=0", l_svalid, l_busy);
        end
    endtask

    task automatic test_parity;
        logic [7:0]    words [2];
        logic [FB-1:0] exps  [2];
        words[0] = 8'h07; words[1] = 8'h03;
`ifdef PISO_PARITY_EN
        exps[0] = 9'b0000_0111_1;
        exps[1] = 9'b0000_0011_0;
`else
        exps[0] = 8'b0000_0111;
        exps[1] = 8'b0000_0011;
`endif
        for (int w = 0; w < 2; w++) begin
            m_data = words[w]; m_valid = 1'b1;
            @(negedge clk);
            m_valid = 1'b0;
            for (int i = 0; i < FB; i++) begin
                n_cmp++;
                if (m_svalid !== 1'b1 || m_sdata !== exps[w][FB-1-i] || m_slast !== (i == FB-1)) begin
                    n_bad++; $display("FAIL parity_w%0d bit%0d got v=%b d=%b l=%b exp v=1 d=%b l=%b",
                                      w, i, m_svalid, m_sdata, m_slast, exps[w][FB-1-i], (i == FB-1));
                end
                @(negedge clk);
            end
            n_cmp++;
            if (m_svalid !== 1'b0) begin
                n_bad++; $display("FAIL parity_w%0d_end got v=%b exp v=0", w, m_svalid);
            end
        end
    endtask

    task automatic test_async_abort;
        logic [FB-1:0] exp;
`ifdef PISO_PARITY_EN
        exp = 9'b1000_0001_0;
`else
        exp = 8'b1000_0001;
`endif
        m_data = 8'hFF; m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (m_svalid !== 1'b1 || m_sdata !== 1'b1 || m_busy !== 1'b1) begin
            n_bad++; $display("FAIL abort_pre got v=%b d=%b b=%b exp 1 1 1", m_svalid, m_sdata, m_busy);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (m_svalid !== 1'b0 || m_sdata !== 1'b0 || m_busy !== 1'b0 || m_slast !== 1'b0) begin
            n_bad++; $display("FAIL abort_async got v=%b d=%b b=%b l=%b exp 0 0 0 0",
                              m_svalid, m_sdata, m_busy, m_slast);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_data = 8'h81; m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        for (int i = 0; i < FB; i++) begin
            n_cmp++;
            if (m_svalid !== 1'b1 || m_sdata !== exp[FB-1-i] || m_slast !== (i == FB-1)) begin
                n_bad++; $display("FAIL abort_81 bit%0d got v=%b d=%b l=%b exp v=1 d=%b l=%b",
                                  i, m_svalid, m_sdata, m_slast, exp[FB-1-i], (i == FB-1));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_input_noise;
        logic [FB-1:0] exp;
`ifdef PISO_PARITY_EN
        exp = 9'b0101_1010_0;
`else
        exp = 8'b0101_1010;
`endif
        m_data = 8'h5A; m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        for (int i = 0; i < FB; i++) begin
            m_data = ~m_data;
            n_cmp++;
            if (m_svalid !== 1'b1 || m_sdata !== exp[FB-1-i] || m_busy !== 1'b1) begin
                n_bad++; $display("FAIL noise_5a bit%0d got v=%b d=%b b=%b exp v=1 d=%b b=1",
                                  i, m_svalid, m_sdata, m_busy, exp[FB-1-i]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (m_busy !== 1'b0 || m_svalid !== 1'b0 || m_ready !== 1'b1) begin
            n_bad++; $display("FAIL noise_idle got b=%b v=%b r=%b exp b=0 v=0 r=1", m_busy, m_svalid, m_ready);
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_back_to_back();
        test_lsb_first();
        test_parity();
        test_async_abort();
        test_input_noise();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
